formacao_inimigos: RTL and testbench

Parametrised enemy-formation controller. Generalises the fixed five-enemy row to N_INIMIGOS enemies and replaces the derived movement clock with an internal clock-enable tick. Marches the formation horizontally, steps down at the screen edges and accelerates as enemies die. Ends the round on victory (all dead) or defeat (formation reaches the base line). Sits inside entities, next to nave and the projectile logic; the collision logic drives acerto_*.

---
 rtl/pkg_jogo.sv | 25 ++
 rtl/busca_extremos.sv | 25 ++
 rtl/formacao_inimigos.sv | 156 +++++++++++++++
 tb/tb_formacao_inimigos.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_jogo.sv
// Shared game constants: screen geometry, coordinate width and the formation FSM encoding.
package pkg_jogo;

    localparam int TELA_LARGURA = 640;
    localparam int TELA_ALTURA  = 480;
    localparam int TELA_X_MAX   = TELA_LARGURA - 1;
    localparam int TELA_Y_BASE  = TELA_ALTURA - 80;
    localparam int CW           = 10;

    typedef enum logic [1:0] {
        MARCHA,
        DESCE,
        FIM
    } estado_t;

    // Tick period shrinks with each kill but never drops below pmin.
    function automatic int calc_periodo(input int base, input int dec, input int pmin,
                                        input int kills);
        int reducao;
        reducao = kills * dec;
        if (reducao >= base - pmin) return pmin;
        return base - reducao;
    endfunction

endpackage

// File: rtl/busca_extremos.sv
// Priority encoder over the alive mask: lowest and highest alive index plus an any-alive flag.
module busca_extremos #(
    parameter int N  = 5,
    parameter int IW = 3
) (
    input  logic [N-1:0]  vivo_i,
    output logic [IW-1:0] imin_o,
    output logic [IW-1:0] imax_o,
    output logic          any_o
);

    always_comb begin
        // NOTE: every output gets a default before the loops so no latch is inferred.
        imin_o = '0;
        imax_o = '0;
        any_o  = |vivo_i;
        for (int i = N - 1; i >= 0; i--) begin
            if (vivo_i[i]) imin_o = IW'(i);
        end
        for (int i = 0; i < N; i++) begin
            if (vivo_i[i]) imax_o = IW'(i);
        end
    end

endmodule

// File: rtl/formacao_inimigos.sv
// Enemy formation: tick divider, march/descend FSM, kill bookkeeping and round end detection.
module formacao_inimigos
    import pkg_jogo::*;
#(
    parameter int N_INIMIGOS = 5,
    parameter int X0         = 40,
    parameter int Y0         = 40,
    parameter int ESPACO_X   = 60,
    parameter int LARGURA    = 45,
    parameter int PASSO_X    = 4,
    parameter int PASSO_Y    = 20,
    parameter int X_MAX      = TELA_X_MAX,
    parameter int Y_BASE     = TELA_Y_BASE,
    parameter int DIV_BASE   = 320000,
    parameter int DIV_DEC    = 40000,
    parameter int DIV_MIN    = 40000,
    localparam int IW        = (N_INIMIGOS > 1) ? $clog2(N_INIMIGOS) : 1,
    localparam int NW        = $clog2(N_INIMIGOS + 1)
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     pausa,
    input  logic                     reiniciar,
    input  logic                     acerto_valido,
    input  logic [IW-1:0]            acerto_idx,
    output logic [CW*N_INIMIGOS-1:0] inimigo_x,
    output logic [CW*N_INIMIGOS-1:0] inimigo_y,
    output logic [N_INIMIGOS-1:0]    vivo,
    output logic [NW-1:0]            n_vivos,
    output logic                     tick,
    output logic                     venceu,
    output logic                     chegou_base
);

    localparam int DW = $clog2(DIV_BASE + 1);

    estado_t               estado_q;
    logic [CW-1:0]         ox_q, oy_q;
    logic                  dir_esq_q;
    logic [N_INIMIGOS-1:0] vivo_q;
    logic [NW-1:0]         n_vivos_q, kills_q;
    logic [DW-1:0]         cnt_q, periodo_q;
    logic                  venceu_q, chegou_q;

    logic [IW-1:0] imin, imax;
    logic          any_vivo;

    busca_extremos #(.N(N_INIMIGOS), .IW(IW)) u_extremos (
        .vivo_i (vivo_q),
        .imin_o (imin),
        .imax_o (imax),
        .any_o  (any_vivo)
    );

    logic          div_en, tick_c, hit_vivo, kill_ok, sai_dir, sai_esq;
    int            borda_dir_px, borda_esq_px, oy_novo;
    logic [DW-1:0] periodo_novo;

    always_comb begin
        div_en   = !pausa && (estado_q != FIM);
        tick_c   = div_en && (cnt_q == periodo_q - DW'(1));

        // Index compare against each slot keeps out-of-range indices harmless.
        hit_vivo = 1'b0;
        for (int i = 0; i < N_INIMIGOS; i++) begin
            if (acerto_idx == IW'(i)) hit_vivo = vivo_q[i];
        end
        kill_ok  = acerto_valido && !pausa && (estado_q != FIM) && hit_vivo;

        borda_dir_px = int'(ox_q) + int'(imax) * ESPACO_X + LARGURA - 1;
        borda_esq_px = int'(ox_q) + int'(imin) * ESPACO_X;
        sai_dir      = any_vivo && (borda_dir_px + PASSO_X > X_MAX);
        sai_esq      = any_vivo && (borda_esq_px < PASSO_X);
        oy_novo      = int'(oy_q) + PASSO_Y;
        periodo_novo = DW'(calc_periodo(DIV_BASE, DIV_DEC, DIV_MIN, int'(kills_q)));
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset || reiniciar) begin
            estado_q  <= MARCHA;
            ox_q      <= CW'(X0);
            oy_q      <= CW'(Y0);
            dir_esq_q <= 1'b0;
            vivo_q    <= '1;
            n_vivos_q <= NW'(N_INIMIGOS);
            kills_q   <= '0;
            cnt_q     <= '0;
            periodo_q <= DW'(DIV_BASE);
            venceu_q  <= 1'b0;
            chegou_q  <= 1'b0;
        end else begin
            if (div_en) begin
                if (tick_c) begin
                    cnt_q     <= '0;
                    periodo_q <= periodo_novo;
                end else begin
                    cnt_q <= cnt_q + DW'(1);
                end
            end

            if (tick_c) begin
                case (estado_q)
                    MARCHA: begin
                        if (!dir_esq_q) begin
                            if (sai_dir) estado_q <= DESCE;
                            else         ox_q     <= ox_q + CW'(PASSO_X);
                        end else begin
                            if (sai_esq) estado_q <= DESCE;
                            else         ox_q     <= ox_q - CW'(PASSO_X);
                        end
                    end
                    DESCE: begin
                        oy_q      <= CW'(oy_novo);
                        dir_esq_q <= !dir_esq_q;
                        if (oy_novo + LARGURA >= Y_BASE) begin
                            chegou_q <= 1'b1;
                            estado_q <= FIM;
                        end else begin
                            estado_q <= MARCHA;
                        end
                    end
                    default: ;
                endcase
            end

            // NOTE: this block comes after the FSM so that, with non-blocking updates, the
            // last kill overrides a defeat decided on the same edge.
            if (kill_ok) begin
                vivo_q[acerto_idx] <= 1'b0;
                n_vivos_q          <= n_vivos_q - NW'(1);
                kills_q            <= kills_q + NW'(1);
                if (n_vivos_q == NW'(1)) begin
                    venceu_q <= 1'b1;
                    chegou_q <= 1'b0;
                    estado_q <= FIM;
                end
            end
        end
    end

    always_comb begin
        inimigo_x = '0;
        inimigo_y = '0;
        for (int i = 0; i < N_INIMIGOS; i++) begin
            inimigo_x[CW*i +: CW] = CW'(int'(ox_q) + i * ESPACO_X);
            inimigo_y[CW*i +: CW] = oy_q;
        end
    end

    assign vivo        = vivo_q;
    assign n_vivos     = n_vivos_q;
    assign tick        = tick_c;
    assign venceu      = venceu_q;
    assign chegou_base = chegou_q;

endmodule

// File: tb/tb_formacao_inimigos.sv
// Directed bench for formacao_inimigos with a short tick period (DIV_BASE=4, DIV_DEC=1, DIV_MIN=2).
module tb_formacao_inimigos;

    logic        clk = 1'b0;
    logic        reset, pausa, reiniciar, acerto_valido;
    logic [2:0]  acerto_idx;
    logic [49:0] inimigo_x, inimigo_y;
    logic [4:0]  vivo;
    logic [2:0]  n_vivos;
    logic        tick, venceu, chegou_base;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    formacao_inimigos #(
        .N_INIMIGOS (5),
        .DIV_BASE   (4),
        .DIV_DEC    (1),
        .DIV_MIN    (2)
    ) dut (
        .CLOCK_50      (clk),
        .reset         (reset),
        .pausa         (pausa),
        .reiniciar     (reiniciar),
        .acerto_valido (acerto_valido),
        .acerto_idx    (acerto_idx),
        .inimigo_x     (inimigo_x),
        .inimigo_y     (inimigo_y),
        .vivo          (vivo),
        .n_vivos       (n_vivos),
        .tick          (tick),
        .venceu        (venceu),
        .chegou_base   (chegou_base)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns the window number (1-based) in which tick was seen, then consumes that edge.
    task automatic wait_tick(output int n);
        #1;
        n = 1;
        while (!tick && n < 1000) begin
            step();
            n++;
        end
        if (!tick) check("tick_timeout", 64'(tick), 64'd1);
        step();
    endtask

    task automatic kill(input int idx);
        acerto_valido = 1'b1;
        acerto_idx    = 3'(idx);
        step();
        acerto_valido = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int n, ticks, x_prev, y_prev;
        logic [49:0] yy_prev;

        reset = 1'b1; pausa = 1'b0; reiniciar = 1'b0;
        acerto_valido = 1'b0; acerto_idx = '0;

        // Reset values and first march
        do_reset();
        check("rst_x0", inimigo_x[9:0], 40);
        check("rst_y", inimigo_y, 64'({5{10'd40}}));
        check("rst_vivo", vivo, 5'b11111);
        check("rst_n_vivos", n_vivos, 5);
        check("rst_tick", tick, 0);
        check("rst_venceu", venceu, 0);
        check("rst_chegou", chegou_base, 0);

        wait_tick(n);
        check("first_tick_cycle", n, 4);
        check("t1_x0", inimigo_x[9:0], 44);
        check("t1_x4", inimigo_x[49:40], 284);
        check("t1_y", inimigo_y, 64'({5{10'd40}}));
        check("t1_vivo", vivo, 5'b11111);
        check("t1_n_vivos", n_vivos, 5);

        for (int k = 2; k <= 78; k++) begin
            wait_tick(n);
            if (k == 2) check("period_full", n, 4);
        end
        check("t78_x0", inimigo_x[9:0], 352);
        wait_tick(n);
        check("t79_turn_x0", inimigo_x[9:0], 352);
        check("t79_y0", inimigo_y[9:0], 40);
        wait_tick(n);
        check("t80_y0", inimigo_y[9:0], 60);
        check("t80_x0", inimigo_x[9:0], 352);
        wait_tick(n);
        check("t81_x0_left", inimigo_x[9:0], 348);

        // Kill the rightmost enemy: faster ticks and a later right turn
        do_reset();
        kill(4);
        check("k4_vivo", vivo, 5'b01111);
        check("k4_n_vivos", n_vivos, 4);
        wait_tick(n);
        wait_tick(n);
        check("period_after_kill", n, 3);
        ticks = 2;
        do begin
            x_prev = int'(inimigo_x[9:0]);
            wait_tick(n);
            ticks++;
        end while (int'(inimigo_x[9:0]) != x_prev && ticks < 200);
        check("turn_x0_4alive", inimigo_x[9:0], 412);
        check("turn_tick_4alive", ticks, 94);
        wait_tick(n);
        check("desc_y0_4alive", inimigo_y[9:0], 60);

        // Duplicate and out-of-range kills
        kill(2);
        check("k2_vivo", vivo, 5'b01011);
        check("k2_n_vivos", n_vivos, 3);
        kill(2);
        check("k2_again_vivo", vivo, 5'b01011);
        check("k2_again_n_vivos", n_vivos, 3);
        kill(7);
        check("k7_vivo", vivo, 5'b01011);
        check("k7_n_vivos", n_vivos, 3);

        // Pause right after a wrap: divider holds at 0
        wait_tick(n);
        pausa = 1'b1;
        x_prev = int'(inimigo_x[9:0]);
        yy_prev = inimigo_y;
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 0) begin
                acerto_valido = 1'b1;
                acerto_idx    = 3'd0;
            end
            #1;
            if (tick) ticks++;
            step();
            acerto_valido = 1'b0;
        end
        check("pause_ticks", ticks, 0);
        check("pause_x0", inimigo_x[9:0], x_prev);
        check("pause_y", inimigo_y, yy_prev);
        check("pause_kill_vivo", vivo, 5'b01011);
        check("pause_kill_n_vivos", n_vivos, 3);
        pausa = 1'b0;
        wait_tick(n);
        check("resume_cycle", n, 2);

        // Victory: kill everyone left
        kill(0);
        kill(1);
        check("pre_last_kill_venceu", venceu, 0);
        kill(3);
        check("win_venceu", venceu, 1);
        check("win_n_vivos", n_vivos, 0);
        check("win_vivo", vivo, 5'b00000);
        check("win_chegou", chegou_base, 0);
        x_prev = int'(inimigo_x[9:0]);
        y_prev = int'(inimigo_y[9:0]);
        ticks = 0;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (tick) ticks++;
            step();
        end
        check("win_no_ticks", ticks, 0);
        check("win_x0_frozen", inimigo_x[9:0], x_prev);
        check("win_y0_frozen", inimigo_y[9:0], y_prev);
        check("win_venceu_sticky", venceu, 1);

        // Defeat: 16 descents to oy=360
        do_reset();
        n = 0;
        while (!chegou_base && n < 20000) begin
            step();
            n++;
        end
        check("lose_chegou", chegou_base, 1);
        check("lose_y0", inimigo_y[9:0], 360);
        check("lose_x0", inimigo_x[9:0], 0);
        check("lose_x4", inimigo_x[49:40], 240);
        check("lose_venceu", venceu, 0);
        y_prev = int'(inimigo_y[9:0]);
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (tick) ticks++;
            step();
        end
        check("lose_no_ticks", ticks, 0);
        check("lose_y0_frozen", inimigo_y[9:0], y_prev);
        kill(1);
        check("fim_kill_vivo", vivo, 5'b11111);
        check("fim_kill_n_vivos", n_vivos, 5);

        // Restart pulse while paused
        pausa = 1'b1;
        reiniciar = 1'b1;
        step();
        reiniciar = 1'b0;
        check("rein_x0", inimigo_x[9:0], 40);
        check("rein_y", inimigo_y, 64'({5{10'd40}}));
        check("rein_vivo", vivo, 5'b11111);
        check("rein_n_vivos", n_vivos, 5);
        check("rein_chegou", chegou_base, 0);
        check("rein_venceu", venceu, 0);
        pausa = 1'b0;
        wait_tick(n);
        check("rein_first_tick_cycle", n, 4);
        check("rein_t1_x0", inimigo_x[9:0], 44);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
